// File: rtl/grant_forwarder.sv
// Responder side of the scheduler grant handshake: pops the granted queue head,
// forwards it over valid/ready, and pulses consumed once it has been accepted.
module grant_forwarder #(
  parameter  int NUMBER_OF_QUEUES = 4,
  parameter  int PACKET_SIZE      = 64,
  parameter  int REGISTER_SIZE    = 32,
  localparam int IDW = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic [IDW-1:0]                                id,
  input  logic [NUMBER_OF_QUEUES-1:0]                   empty,
  input  logic [NUMBER_OF_QUEUES-1:0][PACKET_SIZE-1:0]  heads,
  output logic [NUMBER_OF_QUEUES-1:0]                   pop,
  output logic                                          m_valid,
  output logic [PACKET_SIZE-1:0]                        m_data,
  output logic [IDW-1:0]                                m_id,
  input  logic                                          m_ready,
  output logic                                          consumed,
  output logic                                          busy,
  output logic [REGISTER_SIZE-1:0]                      drop_count,
  output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] served
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [REGISTER_SIZE-1:0] ONE = 1;

  state_t r_state;
  state_t w_next;

  logic [PACKET_SIZE-1:0]                         r_data;
  logic [IDW-1:0]                                 r_id;
  logic [REGISTER_SIZE-1:0]                       r_drop;
  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] r_served;

  logic w_grant;
  logic w_hit;
  logic w_miss;
  logic w_xfer;

  // Grants are only honoured from IDLE and never while reset is high
  assign w_grant = enable & ~reset & (r_state == IDLE);
  assign w_hit   = w_grant & ~empty[id];
  assign w_miss  = w_grant &  empty[id];
  assign w_xfer  = (r_state == SEND) & m_ready;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_hit)       w_next = SEND;
        else if (w_miss) w_next = DONE;
      end
      SEND: if (w_xfer) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    pop = '0;
    if (w_hit) pop[id] = 1'b1;
    m_valid  = (r_state == SEND);
    consumed = (r_state == DONE);
    busy     = (r_state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data   <= '0;
      r_id     <= '0;
      r_drop   <= '0;
      r_served <= '0;
    end else begin
      if (w_hit) begin
        r_data <= heads[id];
        r_id   <= id;
      end
      if (w_miss && r_drop != '1)
        r_drop <= r_drop + ONE;
      if (w_xfer && r_served[r_id] != '1)
        r_served[r_id] <= r_served[r_id] + ONE;
    end
  end

  assign m_data     = r_data;
  assign m_id       = r_id;
  assign drop_count = r_drop;
  assign served     = r_served;

endmodule

// File: tb/tb_grant_forwarder.sv
// Bench for grant_forwarder: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_grant_forwarder;

  localparam int NQ  = 4;
  localparam int PS  = 64;
  localparam int RS  = 6;
  localparam int IDW = 2;
  localparam int SAT = (1 << RS) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [IDW-1:0]        id;
  logic [NQ-1:0]         empty;
  logic [NQ-1:0][PS-1:0] heads;
  logic [NQ-1:0]         pop;
  logic                  m_valid;
  logic [PS-1:0]         m_data;
  logic [IDW-1:0]        m_id;
  logic                  m_ready;
  logic                  consumed;
  logic                  busy;
  logic [RS-1:0]         drop_count;
  logic [NQ-1:0][RS-1:0] served;

  grant_forwarder #(
    .NUMBER_OF_QUEUES(NQ),
    .PACKET_SIZE(PS),
    .REGISTER_SIZE(RS)
  ) dut (
    .clock(clk),
    .reset(rst),
    .enable(en),
    .id(id),
    .empty(empty),
    .heads(heads),
    .pop(pop),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_id(m_id),
    .m_ready(m_ready),
    .consumed(consumed),
    .busy(busy),
    .drop_count(drop_count),
    .served(served)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;
  int proto_err = 0;

  // Model: a packet is either in flight, being retired, or absent
  bit            mo_inflight;
  bit            mo_cons;
  logic [PS-1:0] mo_data;
  int            mo_id;
  int            mo_drop;
  int            mo_served[NQ];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NQ-1:0] exp_pop();
    logic [NQ-1:0] p;
    p = '0;
    if (!rst && en && !mo_inflight && !mo_cons && !empty[id])
      p[id] = 1'b1;
    return p;
  endfunction

  task automatic compare();
    chk("pop", 64'(pop), 64'(exp_pop()));
    chk("m_valid", 64'(m_valid), 64'(mo_inflight));
    chk("consumed", 64'(consumed), 64'(mo_cons));
    chk("busy", 64'(busy), 64'(mo_inflight | mo_cons));
    if (mo_inflight) begin
      chk("m_data", m_data, mo_data);
      chk("m_id", 64'(m_id), 64'(mo_id));
    end
    chk("drop_count", 64'(drop_count), 64'(mo_drop));
    for (int q = 0; q < NQ; q++)
      chk($sformatf("served%0d", q), 64'(served[q]), 64'(mo_served[q]));
  endtask

  function automatic int sat_inc(int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_step();
    if (rst) begin
      mo_inflight = 0;
      mo_cons     = 0;
      mo_drop     = 0;
      for (int q = 0; q < NQ; q++) mo_served[q] = 0;
    end else if (mo_cons) begin
      mo_cons = 0;
      if (en) proto_err++;
    end else if (mo_inflight) begin
      if (en) proto_err++;
      if (m_ready) begin
        mo_served[mo_id] = sat_inc(mo_served[mo_id]);
        mo_inflight = 0;
        mo_cons     = 1;
      end
    end else if (en) begin
      if (!empty[id]) begin
        mo_inflight = 1;
        mo_data     = heads[id];
        mo_id       = int'(id);
      end else begin
        mo_drop = sat_inc(mo_drop);
        mo_cons = 1;
      end
    end
  endtask

  task automatic tick();
    logic       s_rst, s_en, s_rdy;
    logic [1:0] s_id;
    logic [3:0] s_empty;
    logic [NQ-1:0][PS-1:0] s_heads;
    #1 compare();
    s_rst = rst; s_en = en; s_rdy = m_ready;
    s_id = id; s_empty = empty; s_heads = heads;
    @(posedge clk);
    begin
      logic       k_rst, k_en, k_rdy;
      logic [1:0] k_id;
      logic [3:0] k_empty;
      logic [NQ-1:0][PS-1:0] k_heads;
      k_rst = rst; k_en = en; k_rdy = m_ready;
      k_id = id; k_empty = empty; k_heads = heads;
      rst = s_rst; en = s_en; m_ready = s_rdy;
      id = s_id; empty = s_empty; heads = s_heads;
      model_step();
      rst = k_rst; en = k_en; m_ready = k_rdy;
      id = k_id; empty = k_empty; heads = k_heads;
    end
    @(negedge clk);
  endtask

  task automatic grant(int q, logic [PS-1:0] d);
    en = 1'b1;
    id = IDW'(q);
    heads[q] = d;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; id = '0; empty = '0;
    heads = '0; m_ready = 1'b0;
    mo_inflight = 0; mo_cons = 0; mo_data = '0; mo_id = 0; mo_drop = 0;
    for (int q = 0; q < NQ; q++) mo_served[q] = 0;
    @(negedge clk);
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cons", 64'(consumed), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_data", m_data, 64'd0);
    tick();

    // 1: best-case grant
    grant(2, 64'hA5); m_ready = 1'b1;
    #1 chk("t1_pop", 64'(pop), 64'b0100);
    tick();
    en = 1'b0;
    #1 chk("t1_valid", 64'(m_valid), 64'd1);
    chk("t1_data", m_data, 64'hA5);
    chk("t1_id", 64'(m_id), 64'd2);
    chk("t1_cons0", 64'(consumed), 64'd0);
    tick();
    #1 chk("t1_cons", 64'(consumed), 64'd1);
    chk("t1_valid0", 64'(m_valid), 64'd0);
    tick();
    #1 chk("t1_cons_low", 64'(consumed), 64'd0);
    chk("t1_served", 64'(served[2]), 64'd1);
    tick();

    // 2: stall for 5 cycles, id/heads change while in flight
    grant(2, 64'hA5); m_ready = 1'b0;
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      id = IDW'($urandom_range(0, 3));
      heads[2] = {$urandom, $urandom};
      #1 chk("t2_valid", 64'(m_valid), 64'd1);
      chk("t2_data", m_data, 64'hA5);
      tick();
    end
    m_ready = 1'b1;
    #1 chk("t2_valid6", 64'(m_valid), 64'd1);
    tick();
    m_ready = 1'b0;
    #1 chk("t2_cons", 64'(consumed), 64'd1);
    tick();
    #1 chk("t2_served", 64'(served[2]), 64'd2);
    tick();

    // 3: grant to an empty queue
    empty = 4'b0010; grant(1, 64'h11);
    #1 chk("t3_pop", 64'(pop), 64'd0);
    tick();
    en = 1'b0; empty = '0;
    #1 chk("t3_cons", 64'(consumed), 64'd1);
    chk("t3_valid", 64'(m_valid), 64'd0);
    chk("t3_drop", 64'(drop_count), 64'd1);
    tick();
    tick();

    // 4: stray grant during SEND
    grant(3, 64'h33); m_ready = 1'b0;
    tick();
    grant(0, 64'h44);
    #1 chk("t4_pop", 64'(pop), 64'd0);
    tick();
    en = 1'b0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1 chk("t4_cons", 64'(consumed), 64'd1);
    chk("t4_served0", 64'(served[0]), 64'd0);
    chk("t4_served3", 64'(served[3]), 64'd1);
    tick();
    #1 chk("t4_cons_low", 64'(consumed), 64'd0);
    tick();

    // 5: reset while in SEND, then a normal grant
    grant(1, 64'h55);
    tick();
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("t5_valid", 64'(m_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_cons", 64'(consumed), 64'd0);
    chk("t5_served2", 64'(served[2]), 64'd0);
    chk("t5_drop", 64'(drop_count), 64'd0);
    grant(1, 64'h66); m_ready = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    #1 chk("t5_served1", 64'(served[1]), 64'd1);
    tick();

    // 6: saturation of served[0] and drop_count
    for (int i = 0; i < SAT + 5; i++) begin
      grant(0, {$urandom, $urandom}); m_ready = 1'b1;
      tick();
      en = 1'b0;
      tick();
      tick();
    end
    #1 chk("t6_served_sat", 64'(served[0]), 64'(SAT));
    empty = 4'b1000;
    for (int i = 0; i < SAT + 5; i++) begin
      grant(3, 64'h0);
      tick();
      en = 1'b0;
      tick();
    end
    #1 chk("t6_drop_sat", 64'(drop_count), 64'(SAT));
    empty = '0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      en      = ($urandom_range(0, 2) == 0);
      id      = IDW'($urandom_range(0, 3));
      empty   = 4'($urandom);
      m_ready = ($urandom_range(0, 2) != 0);
      for (int q = 0; q < NQ; q++) heads[q] = {$urandom, $urandom};
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
